// File: rtl/sys_tick_scheduler.sv
// -----------------------------------------------------------------------------
// sys_tick_scheduler
//
// Avalon-MM master for a 16-bit interval timer slave. It programs the timer
// period, starts the timer in continuous mode with its interrupt enabled, and
// services every timeout by clearing the status register. Each serviced
// timeout becomes a one-cycle system tick, which advances a free-running tick
// counter and a bank of one-shot/periodic alarm channels.
//
// Ports:
//   clk, reset_n        system clock, asynchronous active-low reset
//   cfg_start/cfg_stop  pulses: (re)program + start / stop the timer
//   cfg_period          timer load value (tick interval = value+1 clocks)
//   busy                programming sequence in flight
//   running             timer started and timeouts being serviced
//   tmr_*               Avalon-MM write-only master port to the timer slave
//   tmr_irq             timer interrupt
//   tick, tick_count    tick pulse and count of serviced timeouts since start
//   arm_*               arm/disarm one alarm channel (arm_ticks=0 disarms)
//   alarm_active        per-channel armed flags
//   alarm_fire          per-channel one-cycle fire pulses
// -----------------------------------------------------------------------------
module sys_tick_scheduler #(
   parameter int NUM_ALARMS = 4,
   parameter int ALARM_W    = 16,
   parameter int TICK_W     = 32,
   parameter int MIN_PERIOD = 16,
   localparam int IDX_W     = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  cfg_start,
   input  logic                  cfg_stop,
   input  logic [31:0]           cfg_period,
   output logic                  busy,
   output logic                  running,
   output logic [2:0]            tmr_address,
   output logic                  tmr_chipselect,
   output logic                  tmr_write_n,
   output logic [15:0]           tmr_writedata,
   input  logic                  tmr_irq,
   output logic                  tick,
   output logic [TICK_W-1:0]     tick_count,
   input  logic                  arm_valid,
   input  logic [IDX_W-1:0]      arm_idx,
   input  logic [ALARM_W-1:0]    arm_ticks,
   input  logic                  arm_periodic,
   output logic [NUM_ALARMS-1:0] alarm_active,
   output logic [NUM_ALARMS-1:0] alarm_fire
);

   typedef enum logic [3:0] {
      S_IDLE, S_W_STOP, S_W_PERL, S_W_PERH, S_W_CTRL, S_W_CLR, S_RUN, S_ACK, S_S_STOP
   } state_t;

   // Timer register map and control words
   localparam logic [2:0]  A_STATUS  = 3'd0;
   localparam logic [2:0]  A_CONTROL = 3'd1;
   localparam logic [2:0]  A_PERL    = 3'd2;
   localparam logic [2:0]  A_PERH    = 3'd3;
   localparam logic [15:0] CTRL_STOP = 16'h0008;
   localparam logic [15:0] CTRL_RUN  = 16'h0007;   // ITO | CONT | START

   state_t      state_q, state_d;
   logic [31:0] period_q;
   logic [31:0] period_clamped;

   logic        cs_d, wr_n_d, busy_d, running_d, tick_d;
   logic [2:0]  addr_d;
   logic [15:0] data_d;

   logic [TICK_W-1:0]  tick_count_q;
   logic [ALARM_W-1:0] count_q  [NUM_ALARMS];
   logic [ALARM_W-1:0] reload_q [NUM_ALARMS];
   logic [NUM_ALARMS-1:0] periodic_q, active_q, fire_q;

   assign period_clamped = (cfg_period < 32'(MIN_PERIOD)) ? 32'(MIN_PERIOD) : cfg_period;

   // ---------------------------------------------------------------- state reg
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process ordering.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= S_IDLE;
         period_q <= '0;
      end else begin
         state_q <= state_d;
         if (state_d == S_W_STOP) period_q <= period_clamped;
      end
   end

   // --------------------------------------------------------------- next state
   // NOTE: every always_comb output gets a default first so no path can infer
   // a latch.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (cfg_start) state_d = S_W_STOP;
         S_W_STOP: state_d = S_W_PERL;
         S_W_PERL: state_d = S_W_PERH;
         S_W_PERH: state_d = S_W_CTRL;
         S_W_CTRL: state_d = S_W_CLR;
         S_W_CLR:  state_d = S_RUN;
         S_RUN: begin
            if (cfg_stop)       state_d = S_S_STOP;
            else if (cfg_start) state_d = S_W_STOP;
            else if (tmr_irq)   state_d = S_ACK;
         end
         S_ACK:    state_d = S_RUN;
         S_S_STOP: state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // ------------------------------------------------------------------ outputs
   // Decoded from the next state and registered, so the bus write lines up
   // with the cycle spent in the corresponding state.
   always_comb begin
      cs_d      = 1'b0;
      wr_n_d    = 1'b1;
      addr_d    = A_STATUS;
      data_d    = '0;
      busy_d    = 1'b0;
      running_d = 1'b0;
      tick_d    = 1'b0;
      case (state_d)
         S_W_STOP: begin cs_d = 1'b1; wr_n_d = 1'b0; addr_d = A_CONTROL; data_d = CTRL_STOP;       busy_d = 1'b1; end
         S_W_PERL: begin cs_d = 1'b1; wr_n_d = 1'b0; addr_d = A_PERL;    data_d = period_q[15:0];  busy_d = 1'b1; end
         S_W_PERH: begin cs_d = 1'b1; wr_n_d = 1'b0; addr_d = A_PERH;    data_d = period_q[31:16]; busy_d = 1'b1; end
         S_W_CTRL: begin cs_d = 1'b1; wr_n_d = 1'b0; addr_d = A_CONTROL; data_d = CTRL_RUN;        busy_d = 1'b1; end
         S_W_CLR:  begin cs_d = 1'b1; wr_n_d = 1'b0; addr_d = A_STATUS;  data_d = '0;              busy_d = 1'b1; end
         S_RUN:    running_d = 1'b1;
         S_ACK:    begin cs_d = 1'b1; wr_n_d = 1'b0; addr_d = A_STATUS; running_d = 1'b1; tick_d = 1'b1; end
         S_S_STOP: begin cs_d = 1'b1; wr_n_d = 1'b0; addr_d = A_CONTROL; data_d = CTRL_STOP; end
         default:  ;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tmr_chipselect <= 1'b0;
         tmr_write_n    <= 1'b1;
         tmr_address    <= '0;
         tmr_writedata  <= '0;
         busy           <= 1'b0;
         running        <= 1'b0;
         tick           <= 1'b0;
         tick_count_q   <= '0;
      end else begin
         tmr_chipselect <= cs_d;
         tmr_write_n    <= wr_n_d;
         tmr_address    <= addr_d;
         tmr_writedata  <= data_d;
         busy           <= busy_d;
         running        <= running_d;
         tick           <= tick_d;
         // Count is updated on the same edge that raises tick.
         if (state_q == S_W_CLR)     tick_count_q <= '0;
         else if (state_d == S_ACK)  tick_count_q <= tick_count_q + TICK_W'(1);
      end
   end

   assign tick_count = tick_count_q;

   // ------------------------------------------------------------------- alarms
   // Alarms advance on the registered tick, so a fire pulse appears in the
   // cycle after the tick. An arm request for a channel overrides that
   // channel's tick in the same cycle.
   // NOTE: the alarm arrays are a few flops per channel, not a RAM, so they
   // are reset along with everything else.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_ALARMS; i++) begin
            count_q[i]  <= '0;
            reload_q[i] <= '0;
         end
         periodic_q <= '0;
         active_q   <= '0;
         fire_q     <= '0;
      end else begin
         for (int i = 0; i < NUM_ALARMS; i++) begin
            fire_q[i] <= 1'b0;
            if (arm_valid && (arm_idx == IDX_W'(i))) begin
               count_q[i]    <= arm_ticks;
               reload_q[i]   <= arm_ticks;
               periodic_q[i] <= arm_periodic;
               active_q[i]   <= (arm_ticks != '0);
            end else if (tick && active_q[i]) begin
               if (count_q[i] == ALARM_W'(1)) begin
                  fire_q[i] <= 1'b1;
                  if (periodic_q[i]) count_q[i]  <= reload_q[i];
                  else               active_q[i] <= 1'b0;
               end else begin
                  count_q[i] <= count_q[i] - ALARM_W'(1);
               end
            end
         end
      end
   end

   assign alarm_active = active_q;
   assign alarm_fire   = fire_q;

endmodule

// File: tb/tb_sys_tick_scheduler.sv
// -----------------------------------------------------------------------------
// tb_sys_tick_scheduler
//
// Bench for sys_tick_scheduler. Contains a behavioural interval-timer slave,
// a bus write log, and an alarm reference model stepped once per timer
// timeout. Directed steps cover programming, servicing, clamping, priority
// and reset; a randomized phase arms channels and compares against the model.
// -----------------------------------------------------------------------------
module tb_sys_tick_scheduler;

   localparam int NUM_ALARMS = 4;
   localparam int ALARM_W    = 16;
   localparam int TICK_W     = 32;
   localparam int IDX_W      = 2;
   localparam int MIN_PERIOD = 16;

   logic                  clk = 1'b0;
   logic                  reset_n = 1'b0;
   logic                  cfg_start = 1'b0;
   logic                  cfg_stop = 1'b0;
   logic [31:0]           cfg_period = '0;
   logic                  busy, running;
   logic [2:0]            tmr_address;
   logic                  tmr_chipselect, tmr_write_n;
   logic [15:0]           tmr_writedata;
   logic                  tmr_irq;
   logic                  tick;
   logic [TICK_W-1:0]     tick_count;
   logic                  arm_valid = 1'b0;
   logic [IDX_W-1:0]      arm_idx = '0;
   logic [ALARM_W-1:0]    arm_ticks = '0;
   logic                  arm_periodic = 1'b0;
   logic [NUM_ALARMS-1:0] alarm_active, alarm_fire;

   always #5 clk = ~clk;

   sys_tick_scheduler #(
      .NUM_ALARMS(NUM_ALARMS), .ALARM_W(ALARM_W), .TICK_W(TICK_W), .MIN_PERIOD(MIN_PERIOD)
   ) dut (
      .clk(clk), .reset_n(reset_n),
      .cfg_start(cfg_start), .cfg_stop(cfg_stop), .cfg_period(cfg_period),
      .busy(busy), .running(running),
      .tmr_address(tmr_address), .tmr_chipselect(tmr_chipselect),
      .tmr_write_n(tmr_write_n), .tmr_writedata(tmr_writedata), .tmr_irq(tmr_irq),
      .tick(tick), .tick_count(tick_count),
      .arm_valid(arm_valid), .arm_idx(arm_idx), .arm_ticks(arm_ticks),
      .arm_periodic(arm_periodic),
      .alarm_active(alarm_active), .alarm_fire(alarm_fire)
   );

   // ------------------------------------------------------ interval timer model
   logic        t_run = 1'b0, t_cont = 1'b0, t_ito = 1'b0, t_to = 1'b0;
   logic [15:0] t_pl = '0, t_ph = '0;
   logic [31:0] t_cnt = '0;
   int          to_events = 0;

   assign tmr_irq = t_to & t_ito;

   always @(posedge clk) begin
      if (t_run) begin
         if (t_cnt == 0) begin
            t_to      <= 1'b1;
            to_events <= to_events + 1;
            t_cnt     <= {t_ph, t_pl};
            if (!t_cont) t_run <= 1'b0;
         end else begin
            t_cnt <= t_cnt - 1;
         end
      end
      if (tmr_chipselect && !tmr_write_n) begin
         case (tmr_address)
            3'd0: t_to <= 1'b0;
            3'd1: begin
               t_ito  <= tmr_writedata[0];
               t_cont <= tmr_writedata[1];
               if (tmr_writedata[3]) t_run <= 1'b0;
               else if (tmr_writedata[2]) begin
                  t_run <= 1'b1;
                  t_cnt <= {t_ph, t_pl};
               end
            end
            3'd2: t_pl <= tmr_writedata;
            3'd3: t_ph <= tmr_writedata;
            default: ;
         endcase
      end
   end

   // ----------------------------------------------------------- bench state
   int          vectors = 0;
   int          miscompares = 0;
   logic [18:0] wlog[$];
   int          cyc = 0, busy_cnt = 0, tick_cnt = 0, tick_seq = 0, stray_fires = 0;
   int          fire_cnt [NUM_ALARMS];
   logic [31:0] fire_mask [NUM_ALARMS];
   int          last_tick_cyc = -1, min_int = 0, max_int = 0;
   bit          prev_tick = 1'b0, prev_irq = 1'b0, irq_rose = 1'b0, irq_pend = 1'b0, irq_chk_en = 1'b0;
   int          irq_rises = 0, irq_acked = 0;

   // Alarm reference model
   int m_cnt [NUM_ALARMS];
   int m_rel [NUM_ALARMS];
   int m_fires [NUM_ALARMS];
   bit m_act [NUM_ALARMS];
   bit m_per [NUM_ALARMS];
   int applied = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
      cyc++;
      if (tmr_chipselect && !tmr_write_n) wlog.push_back({tmr_address, tmr_writedata});
      busy_cnt += int'(busy);
      if (irq_chk_en && irq_pend) begin
         irq_rises++;
         if (tmr_chipselect && !tmr_write_n && tmr_address == 3'd0) irq_acked++;
      end
      irq_rose = tmr_irq && !prev_irq;
      irq_pend = irq_rose;
      prev_irq = tmr_irq;
      for (int ch = 0; ch < NUM_ALARMS; ch++) begin
         if (alarm_fire[ch]) begin
            fire_cnt[ch]++;
            fire_mask[ch] |= 32'(1) << tick_seq;
            if (!prev_tick) stray_fires++;
         end
      end
      if (tick) begin
         tick_cnt++;
         tick_seq++;
         if (last_tick_cyc >= 0) begin
            if (min_int == 0 || cyc - last_tick_cyc < min_int) min_int = cyc - last_tick_cyc;
            if (cyc - last_tick_cyc > max_int) max_int = cyc - last_tick_cyc;
         end
         last_tick_cyc = cyc;
      end
      prev_tick = tick;
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic start_prog(input logic [31:0] p);
      wlog.delete();
      busy_cnt   = 0;
      cfg_period = p;
      cfg_start  = 1'b1;
      step();
      cfg_start  = 1'b0;
   endtask

   task automatic arm(input int idx, input int t, input bit per);
      arm_valid    = 1'b1;
      arm_idx      = IDX_W'(idx);
      arm_ticks    = ALARM_W'(t);
      arm_periodic = per;
      step();
      arm_valid    = 1'b0;
      arm_ticks    = '0;
      arm_periodic = 1'b0;
   endtask

   task automatic wait_tick(input int bound, input string tag);
      int n = 0;
      do begin
         step();
         n++;
      end while (!tick && n < bound);
      check({tag, "_timeout"}, 64'(!tick), 64'(0));
   endtask

   task automatic check_prog(input string tag, input logic [31:0] p);
      logic [18:0] exp_w [5];
      exp_w[0] = {3'd1, 16'h0008};
      exp_w[1] = {3'd2, p[15:0]};
      exp_w[2] = {3'd3, p[31:16]};
      exp_w[3] = {3'd1, 16'h0007};
      exp_w[4] = {3'd0, 16'h0000};
      check({tag, "_nwrites"}, 64'(wlog.size()), 64'(5));
      for (int i = 0; i < 5; i++)
         check($sformatf("%s_w%0d", tag, i), (i < wlog.size()) ? wlog[i] : 19'h7ffff, exp_w[i]);
   endtask

   function automatic void model_arm(input int idx, input int t, input bit per);
      m_cnt[idx] = t;
      m_rel[idx] = t;
      m_per[idx] = per;
      m_act[idx] = (t != 0);
   endfunction

   // One timeout worth of alarm behaviour, straight from the channel rules.
   function automatic void model_sync();
      while (applied < to_events) begin
         for (int ch = 0; ch < NUM_ALARMS; ch++) begin
            if (m_act[ch]) begin
               if (m_cnt[ch] == 1) begin
                  m_fires[ch]++;
                  if (m_per[ch]) m_cnt[ch] = m_rel[ch];
                  else           m_act[ch] = 1'b0;
               end else begin
                  m_cnt[ch]--;
               end
            end
         end
         applied++;
      end
   endfunction

   function automatic logic [NUM_ALARMS-1:0] model_active();
      logic [NUM_ALARMS-1:0] a = '0;
      for (int ch = 0; ch < NUM_ALARMS; ch++) a[ch] = m_act[ch];
      return a;
   endfunction

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded its time budget");
      $fatal(1, "watchdog");
   end

   initial begin
      int t0, t_rand, p_rand, idx, per;
      logic [31:0] p_exp;
      for (int ch = 0; ch < NUM_ALARMS; ch++) begin
         fire_cnt[ch] = 0;
         fire_mask[ch] = '0;
         m_fires[ch] = 0;
         model_arm(ch, 0, 1'b0);
      end

      // ---- reset state
      steps(3);
      check("rst_bus", {tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata}, {1'b0, 1'b1, 3'd0, 16'h0});
      check("rst_flags", {busy, running, tick}, 3'b000);
      check("rst_tick_count", tick_count, 0);
      check("rst_alarms", {alarm_active, alarm_fire}, 8'h00);
      reset_n = 1'b1;
      steps(2);

      // ---- programming sequence with a 32-bit period
      start_prog(32'h0001_86A0);
      steps(7);
      check_prog("prog186a0", 32'h0001_86A0);
      check("prog_busy_cycles", 64'(busy_cnt), 64'(5));
      check("prog_running", running, 1'b1);

      // ---- reprogram from RUN with period 99: tick every 100 clocks
      t0 = tick_cnt;
      min_int = 0; max_int = 0; last_tick_cyc = -1;
      irq_rises = 0; irq_acked = 0; irq_chk_en = 1'b1;
      start_prog(32'd99);
      steps(7);
      check_prog("prog99", 32'd99);
      steps(1042);
      irq_chk_en = 1'b0;
      check("ticks_in_1000", 64'(tick_cnt - t0), 64'(10));
      check("tick_count_10", tick_count, 10);
      check("tick_interval_min", 64'(min_int), 64'(100));
      check("tick_interval_max", 64'(max_int), 64'(100));
      check("irq_rises", 64'(irq_rises), 64'(10));
      check("irq_acked_next_cycle", 64'(irq_acked), 64'(irq_rises));

      // ---- one-shot ch2 (3 ticks) and periodic ch0 (2 ticks)
      tick_seq = 0; stray_fires = 0;
      for (int ch = 0; ch < NUM_ALARMS; ch++) fire_mask[ch] = '0;
      arm(2, 3, 1'b0);
      arm(0, 2, 1'b1);
      check("armed_active", alarm_active, 4'b0101);
      for (int n = 0; n < 800 && tick_seq < 6; n++) step();
      steps(3);
      check("six_ticks_seen", 64'(tick_seq), 64'(6));
      check("ch2_fire_ticks", fire_mask[2], 32'h0000_0008);
      check("ch0_fire_ticks", fire_mask[0], 32'h0000_0054);
      check("fire_after_tick", 64'(stray_fires), 64'(0));
      check("active_after_oneshot", alarm_active, 4'b0001);
      arm(0, 0, 1'b0);
      check("disarm_ch0", alarm_active, 4'b0000);

      // ---- arm ch1 in the same cycle as a tick: arm wins
      wait_tick(200, "sameclk_wait");
      arm_valid = 1'b1; arm_idx = 2'd1; arm_ticks = 16'd2; arm_periodic = 1'b0;
      tick_seq = 0; fire_mask[1] = '0;
      step();
      arm_valid = 1'b0; arm_ticks = '0;
      for (int n = 0; n < 400 && tick_seq < 3; n++) step();
      steps(3);
      check("sameclk_ch1_fire", fire_mask[1], 32'h0000_0004);
      check("sameclk_ch1_done", alarm_active[1], 1'b0);

      // ---- small period is clamped to MIN_PERIOD
      start_prog(32'd3);
      steps(7);
      check_prog("clamp3", 32'd16);

      // ---- randomized arming against the alarm model
      for (int ch = 0; ch < NUM_ALARMS; ch++) arm(ch, 0, 1'b0);
      for (int ch = 0; ch < NUM_ALARMS; ch++) begin
         model_arm(ch, 0, 1'b0);
         m_fires[ch] = fire_cnt[ch];
      end
      applied = to_events;
      for (int it = 0; it < 40; it++) begin
         wait_tick(100, "rnd_wait");
         steps(4);
         model_sync();
         check($sformatf("rnd%0d_active", it), alarm_active, model_active());
         for (int ch = 0; ch < NUM_ALARMS; ch++)
            check($sformatf("rnd%0d_fires_ch%0d", it, ch), 64'(fire_cnt[ch]), 64'(m_fires[ch]));
         if (it == 20) begin
            cfg_stop = 1'b1;
            step();
            cfg_stop = 1'b0;
            steps(3);
            check("rnd_stopped", {running, busy}, 2'b00);
            p_rand = int'($urandom_range(0, 30));
            p_exp  = (p_rand < MIN_PERIOD) ? 32'(MIN_PERIOD) : 32'(p_rand);
            start_prog(32'(p_rand));
            steps(6);
            check_prog("rnd_restart", p_exp);
            check("rnd_restart_count", tick_count, 0);
         end
         idx    = int'($urandom_range(0, NUM_ALARMS - 1));
         t_rand = int'($urandom_range(0, 4));
         per    = int'($urandom_range(0, 1));
         arm(idx, t_rand, per[0]);
         model_arm(idx, t_rand, per[0]);
      end

      // ---- cfg_stop and tmr_irq in the same RUN cycle
      begin
         int n = 0;
         do begin
            step();
            n++;
         end while (!irq_rose && n < 100);
         check("stopirq_wait_timeout", 64'(!irq_rose), 64'(0));
      end
      wlog.delete();
      t0 = tick_cnt;
      cfg_stop = 1'b1;
      step();
      cfg_stop = 1'b0;
      steps(2);
      check("stopirq_nwrites", 64'(wlog.size()), 64'(1));
      check("stopirq_write", (wlog.size() > 0) ? wlog[0] : 19'h7ffff, {3'd1, 16'h0008});
      check("stopirq_no_tick", 64'(tick_cnt - t0), 64'(0));
      check("stopirq_idle", {running, busy}, 2'b00);

      // ---- cfg_start during W_PERH is ignored
      start_prog(32'd50);
      steps(2);
      cfg_start = 1'b1;
      step();
      cfg_start = 1'b0;
      steps(4);
      check_prog("perh_start", 32'd50);
      check("perh_busy_cycles", 64'(busy_cnt), 64'(5));
      check("perh_running", running, 1'b1);

      // ---- asynchronous reset while in W_PERL
      start_prog(32'h0001_86A0);
      step();
      check("rstmid_in_perl", {tmr_address, tmr_writedata}, {3'd2, 16'h86A0});
      #1 reset_n = 1'b0;
      #1;
      check("rstmid_bus", {tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata}, {1'b0, 1'b1, 3'd0, 16'h0});
      check("rstmid_flags", {busy, running, tick}, 3'b000);
      check("rstmid_state", {tick_count, alarm_active, alarm_fire}, 40'h0);
      steps(2);
      reset_n = 1'b1;
      wlog.delete();
      busy_cnt = 0;
      steps(6);
      check("rstmid_stays_idle", 64'(wlog.size() + busy_cnt), 64'(0));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
